// File: rtl/sc_lane_shifter.sv
// sc_lane_shifter: per-lane vehicle pattern rotator driven by the velocity-stage tick.
// Rotates the occupancy pattern one cell per rising tick edge while running, counts
// executed shifts modulo LANE_WIDTH, pulses on full rotation and flags frog collisions.
// Optional feature macro: SC_LANE_BIDIR_EN (adds SC_LANE_DIR_IN, overrides DIR).
module sc_lane_shifter #(
  parameter int unsigned LANE_WIDTH = 8,
  parameter int unsigned DIR        = 0
) (
  input  logic                          SC_VEL_CLOCK_50,
  input  logic                          SC_VEL_RESET,
  input  logic                          SC_LANE_TICK_IN,
  input  logic                          SC_LANE_LOAD_IN,
  input  logic [LANE_WIDTH-1:0]         SC_LANE_PATTERN_IN,
  input  logic                          SC_LANE_ENABLE_IN,
  input  logic [LANE_WIDTH-1:0]         SC_LANE_FROG_MASK_IN,
`ifdef SC_LANE_BIDIR_EN
  input  logic                          SC_LANE_DIR_IN,
`endif
  output logic [LANE_WIDTH-1:0]         SC_LANE_DATA_OUT,
  output logic                          SC_LANE_STEP_OUT,
  output logic [$clog2(LANE_WIDTH)-1:0] SC_LANE_STEPS_OUT,
  output logic                          SC_LANE_WRAP_OUT,
  output logic                          SC_LANE_HIT_OUT
);

  localparam int unsigned StepsW = $clog2(LANE_WIDTH);
  localparam logic [StepsW-1:0] StepsMax = StepsW'(LANE_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  r_tick_prev;
  logic [LANE_WIDTH-1:0] r_data;
  logic [StepsW-1:0]     r_steps;
  logic                  r_step;
  logic                  r_wrap;
  logic                  r_hit;

  logic                  w_dir;
  logic                  w_edge;
  logic                  w_shift;
  logic                  w_last_step;
  logic [LANE_WIDTH-1:0] w_rot;

`ifdef SC_LANE_BIDIR_EN
  assign w_dir = SC_LANE_DIR_IN;
`else
  assign w_dir = (DIR != 0);
`endif

  assign w_edge      = SC_LANE_TICK_IN & ~r_tick_prev;
  // Load always wins over a coincident edge; state and enable must both allow the shift.
  assign w_shift     = (r_state == StRun) & SC_LANE_ENABLE_IN & w_edge & ~SC_LANE_LOAD_IN;
  assign w_last_step = (r_steps == StepsMax);
  assign w_rot       = w_dir ? {r_data[0], r_data[LANE_WIDTH-1:1]}
                             : {r_data[LANE_WIDTH-2:0], r_data[LANE_WIDTH-1]};

  // State register.
  always_ff @(posedge SC_VEL_CLOCK_50 or posedge SC_VEL_RESET) begin
    if (SC_VEL_RESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: load from any state, enable toggles between run and pause.
  always_comb begin
    w_state_nxt = r_state;
    if (SC_LANE_LOAD_IN) begin
      w_state_nxt = SC_LANE_ENABLE_IN ? StRun : StPause;
    end else begin
      unique case (r_state)
        StRun:   if (!SC_LANE_ENABLE_IN) w_state_nxt = StPause;
        StPause: if (SC_LANE_ENABLE_IN)  w_state_nxt = StRun;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Tick history, sampled every cycle regardless of state.
  always_ff @(posedge SC_VEL_CLOCK_50 or posedge SC_VEL_RESET) begin
    if (SC_VEL_RESET) begin
      r_tick_prev <= 1'b0;
    end else begin
      r_tick_prev <= SC_LANE_TICK_IN;
    end
  end

  // Pattern, step counter and step/wrap pulses.
  always_ff @(posedge SC_VEL_CLOCK_50 or posedge SC_VEL_RESET) begin
    if (SC_VEL_RESET) begin
      r_data  <= '0;
      r_steps <= '0;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (SC_LANE_LOAD_IN) begin
      r_data  <= SC_LANE_PATTERN_IN;
      r_steps <= '0;
      r_step  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_step <= w_shift;
      r_wrap <= w_shift & w_last_step;
      if (w_shift) begin
        r_data  <= w_rot;
        r_steps <= w_last_step ? '0 : r_steps + StepsW'(1);
      end
    end
  end

  // Collision flag from the currently displayed pattern; suppressed before the first load.
  always_ff @(posedge SC_VEL_CLOCK_50 or posedge SC_VEL_RESET) begin
    if (SC_VEL_RESET) begin
      r_hit <= 1'b0;
    end else begin
      r_hit <= (r_state != StIdle) & (|(r_data & SC_LANE_FROG_MASK_IN));
    end
  end

  assign SC_LANE_DATA_OUT  = r_data;
  assign SC_LANE_STEP_OUT  = r_step;
  assign SC_LANE_STEPS_OUT = r_steps;
  assign SC_LANE_WRAP_OUT  = r_wrap;
  assign SC_LANE_HIT_OUT   = r_hit;

endmodule

// File: tb/tb_sc_lane_shifter.sv
// Scoreboard bench for sc_lane_shifter (default LANE_WIDTH=8, DIR=0).
module tb_sc_lane_shifter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, load = 1'b0, en = 1'b0, dir_in = 1'b0;
  logic [7:0] pat = '0, frog = '0;
  logic [7:0] data;
  logic       step, wrap, hit;
  logic [2:0] steps;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int d;
    int s;
    int w;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: lane state as plain integers.
  int m_state = 0;  // 0 idle, 1 run, 2 pause
  int m_data  = 0;
  int m_steps = 0;
  int m_prev  = 0;

  always #5 clk = ~clk;

  sc_lane_shifter dut (
    .SC_VEL_CLOCK_50     (clk),
    .SC_VEL_RESET        (rst),
    .SC_LANE_TICK_IN     (tick),
    .SC_LANE_LOAD_IN     (load),
    .SC_LANE_PATTERN_IN  (pat),
    .SC_LANE_ENABLE_IN   (en),
    .SC_LANE_FROG_MASK_IN(frog),
`ifdef SC_LANE_BIDIR_EN
    .SC_LANE_DIR_IN      (dir_in),
`endif
    .SC_LANE_DATA_OUT    (data),
    .SC_LANE_STEP_OUT    (step),
    .SC_LANE_STEPS_OUT   (steps),
    .SC_LANE_WRAP_OUT    (wrap),
    .SC_LANE_HIT_OUT     (hit)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Rotate toward MSB by one cell: double, carry the top vehicle around to cell 0.
  function automatic int rot_up(input int d);
    return (d * 2 + d / 128) % 256;
  endfunction

  // One clock of stimulus; model advances alongside, per-cycle state checked after the edge.
  task automatic cycle(input int t, input int ld, input int p, input int e, input int f);
    int edge_seen, sh, exp_hit;
    tick = t[0];
    load = ld[0];
    pat  = p[7:0];
    en   = e[0];
    frog = f[7:0];
    edge_seen = (t != 0 && m_prev == 0) ? 1 : 0;
    m_prev    = t;
    exp_hit   = (m_state != 0 && (m_data & f) != 0) ? 1 : 0;
    sh        = 0;
    if (ld != 0) begin
      m_data  = p % 256;
      m_steps = 0;
      m_state = (e != 0) ? 1 : 2;
    end else begin
      if (m_state == 1 && e != 0 && edge_seen != 0) begin
        sh      = 1;
        m_data  = rot_up(m_data);
        m_steps = (m_steps + 1) % 8;
      end
      if (m_state == 1 && e == 0) m_state = 2;
      else if (m_state == 2 && e != 0) m_state = 1;
    end
    @(posedge clk);
    #1;
    if (sh != 0) exp_q.push_back('{m_data, m_steps, (m_steps == 0) ? 1 : 0});
    chk("data", int'(data), m_data);
    chk("steps", int'(steps), m_steps);
    chk("hit", int'(hit), exp_hit);
  endtask

  // Monitor: each STEP pulse must match the oldest expected shift.
  always @(negedge clk) begin
    if (!rst) begin
      if (step) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_step", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("step_data", int'(data), e.d);
          chk("step_steps", int'(steps), e.s);
          chk("step_wrap", int'(wrap), e.w);
        end
      end else begin
        chk("missing_step", exp_q.size(), 0);
        chk("wrap_without_step", int'(wrap), 0);
      end
    end
  end

  initial begin
    #2;
    chk("rst_data", int'(data), 0);
    chk("rst_steps", int'(steps), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_hit", int'(hit), 0);
    #10 rst = 1'b0;

    // Ticks before any load are ignored in idle.
    cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);

    // Load 0x03 and run three single-cycle ticks.
    cycle(0, 1, 8'h03, 1, 0);
    chk("load_data", int'(data), 8'h03);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
    end
    chk("three_ticks_data", int'(data), 8'h18);
    chk("three_ticks_steps", int'(steps), 3);

    // Full rotation from 0x81.
    cycle(0, 1, 8'h81, 1, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 0, 1, 0);
      cycle(0, 0, 0, 1, 0);
    end
    chk("full_rot_data", int'(data), 8'h81);
    chk("full_rot_steps", int'(steps), 0);

    // Level held high gives one shift.
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    chk("held_tick_data", int'(data), 8'h03);

    // Paused ticks are discarded, then shifting resumes.
    for (int i = 0; i < 2; i++) begin
      cycle(1, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
    end
    chk("pause_data", int'(data), 8'h03);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    chk("resume_data", int'(data), 8'h06);

    // Enable falling with a tick edge: no shift.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);

    // Back-to-back ticks: two shifts.
    cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);

    // Load coincident with a tick edge wins; then frog collision.
    cycle(1, 1, 8'h10, 1, 0);
    chk("load_vs_tick_data", int'(data), 8'h10);
    chk("load_vs_tick_steps", int'(steps), 0);
    cycle(0, 0, 0, 1, 8'h10);
    chk("hit_set", int'(hit), 1);
    cycle(0, 0, 0, 1, 8'h01);
    chk("hit_clear", int'(hit), 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int f;
      f = ($urandom % 2 != 0) ? (1 << ($urandom % 8)) : 0;
      cycle($urandom % 2, ($urandom % 16 == 0) ? 1 : 0, $urandom % 256,
            ($urandom % 8 != 0) ? 1 : 0, f);
    end

    // Asynchronous reset mid-run with tick held across release.
    cycle(0, 1, 8'h55, 1, 8'h01);
    cycle(1, 0, 0, 1, 8'h01);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_data", int'(data), 0);
    chk("async_rst_steps", int'(steps), 0);
    chk("async_rst_step", int'(step), 0);
    chk("async_rst_wrap", int'(wrap), 0);
    chk("async_rst_hit", int'(hit), 0);
    m_state = 0; m_data = 0; m_steps = 0; m_prev = 0;
    exp_q.delete();
    tick = 1'b1;
    #1 rst = 1'b0;
    cycle(1, 0, 0, 1, 8'hFF);
    cycle(1, 0, 0, 1, 8'hFF);
    cycle(0, 0, 0, 1, 8'hFF);
    chk("post_rst_data", int'(data), 0);

    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_lane_shifter.md
# sc_lane_shifter

Vehicle-lane rotator for the traffic level; it consumes the one-cycle speed tick produced by the lane's velocity stage and rotates a one-hot-per-cell vehicle occupancy pattern by one cell per tick. It also provides a step count, a full-rotation pulse and a registered collision flag against the frog's cell mask. One instance sits per lane, between the velocity stage and the display/collision logic.

## Interface
- LANE_WIDTH, 8, number of cells in the lane (≥2)
- DIR, 0, fixed rotate direction: 0 = toward MSB, 1 = toward LSB
- SC_VEL_CLOCK_50  in  1  system clock, 50 MHz
- SC_VEL_RESET  in  1  reset; SC_VEL_RESET is asynchronous and active-high, and the clock is SC_VEL_CLOCK_50
- SC_LANE_TICK_IN  in  1  speed tick from the velocity stage; one shift per rising edge
- SC_LANE_LOAD_IN  in  1  synchronous load of the pattern
- SC_LANE_PATTERN_IN  in  LANE_WIDTH  pattern captured on load
- SC_LANE_ENABLE_IN  in  1  1 = run, 0 = pause
- SC_LANE_FROG_MASK_IN  in  LANE_WIDTH  frog cell mask, one-hot or zero
- SC_LANE_DATA_OUT  out  LANE_WIDTH  current occupancy, registered
- SC_LANE_STEP_OUT  out  1  one-cycle pulse on each executed shift
- SC_LANE_STEPS_OUT  out  $clog2(LANE_WIDTH)  shifts since the last load, modulo LANE_WIDTH
- SC_LANE_WRAP_OUT  out  1  one-cycle pulse when STEPS wraps from LANE_WIDTH-1 to 0
- SC_LANE_HIT_OUT  out  1  registered collision flag

## Operation
- States:
  - IDLE: reset state; data is held at 0.
  - RUN: ticks shift the pattern.
  - PAUSE: ticks are discarded; data is held.
- Transitions:
  - LOAD_IN=1 in any state: DATA←PATTERN_IN, STEPS←0, STEP/WRAP←0; next state is RUN if ENABLE_IN=1, else PAUSE.
  - RUN→PAUSE when ENABLE_IN=0 and LOAD_IN=0.
  - PAUSE→RUN when ENABLE_IN=1 and LOAD_IN=0.
  - IDLE is left only by a load.
- Tick edge detect:
  - tick_prev is a register of TICK_IN, updated every cycle in all states.
  - An edge is TICK_IN=1 and tick_prev=0.
  - A TICK_IN level held high produces exactly one shift.
- Shift in RUN on an edge:
  - DIR=0: DATA←{DATA[W-2:0],DATA[W-1]}.
  - DIR=1: DATA←{DATA[0],DATA[W-1:1]}.
  - The rotation conserves the number of vehicles; all-zero and all-one patterns stay unchanged but still count as steps.
- STEPS increments on every shift and wraps LANE_WIDTH-1→0. WRAP_OUT pulses on the shift that wraps, coincident with STEP_OUT.
- HIT_OUT←|(DATA_OUT & FROG_MASK_IN) in RUN and PAUSE; it is forced to 0 in IDLE.

## Timing
- Reset values: DATA_OUT=0, STEP_OUT=0, STEPS_OUT=0, WRAP_OUT=0, HIT_OUT=0; state=IDLE; tick_prev=0.
- The tick is first sampled high at edge k. DATA_OUT, STEPS_OUT and STEP_OUT update at edge k, so they are visible in cycle k+1. STEP_OUT lasts exactly one cycle.
- LOAD sampled at edge k: the new pattern is visible in cycle k+1.
- HIT_OUT is one cycle behind DATA_OUT and FROG_MASK_IN.
- Simultaneous events:
  - LOAD together with a tick edge: load wins and the edge is discarded.
  - ENABLE falling together with a tick edge: the shift is not executed, because state and enable are evaluated together (RUN and ENABLE_IN=1 are both required).
- Reset mid-operation: all outputs clear immediately (asynchronously); a tick that is still high when reset releases does not shift, because the block is in IDLE.
- Back-to-back ticks (TICK high, low, high in consecutive cycles) give two shifts two cycles apart.

## Configuration
- Macro SC_LANE_BIDIR_EN.
- Defined:
  - Adds port SC_LANE_DIR_IN (in, 1), which selects the direction per shift.
  - The DIR parameter is ignored.
  - A DIR_IN change takes effect on the next edge; it does not reset STEPS.
- Undefined: the port is absent and the direction is fixed by DIR.

## Test plan
- Reset, then LOAD with PATTERN=8'b0000_0011 and ENABLE=1: cycle after load DATA=0x03, STEPS=0, HIT=0, state RUN.
- DIR=0: three single-cycle ticks → DATA 0x06, 0x0C, 0x18; three STEP pulses; STEPS=3.
- Eight ticks from 0x81:
  - DATA returns to 0x81.
  - WRAP pulses only on the 8th shift, together with STEP; STEPS=0.
- TICK held high for 5 cycles → exactly one shift. ENABLE=0 with 2 ticks → DATA unchanged and no STEP; re-enabling resumes shifting on the next edge.
- LOAD asserted in the same cycle as a tick edge with PATTERN=0x10 → DATA=0x10 and STEPS=0, with no shift applied. Then FROG_MASK=0x10 → HIT=1 one cycle later.
- Assert reset asynchronously mid-RUN → all outputs 0 with no clock edge needed; a tick held high across reset release causes no shift.
